// File: rtl/pipe_word_packer.sv
// Packs 32-bit host pipe words into 64-bit pairs, buffers them,
// and feeds the write-path checker one word per cycle.
module pipe_word_packer #(
  parameter int DEPTH       = 8,
  parameter bit SWAP_HALVES = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word_count,
  input  logic [31:0] pipe_data,
  input  logic        pipe_write,
  output logic        pipe_ready,
  input  logic        hold,
  output logic [63:0] data_to_check,
  output logic        check_for_errors,
  output logic        enable_pattern,
  output logic        busy,
  output logic        done,
  output logic        overflow_err,
  output logic [31:0] words_checked
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0] count_q;
  logic [31:0] words_accepted;
  logic        half_vld;
  logic [31:0] half_q;

  logic [63:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;

  logic        fifo_full;
  logic        fifo_empty;
  logic        launch;
  logic        accept;
  logic        push;
  logic        pop;
  logic [63:0] pair;

  assign fifo_full  = (occ == (AW+1)'(DEPTH));
  assign fifo_empty = (occ == '0);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  assign pipe_ready = busy && !fifo_full &&
                      (words_accepted < count_q);

  // start is only honoured outside RUN
  assign launch = start && (state != RUN);
  assign accept = pipe_write && pipe_ready;
  assign push   = accept && half_vld;
  assign pop    = busy && !fifo_empty && !hold;

  assign pair = SWAP_HALVES ? {half_q, pipe_data}
                            : {pipe_data, half_q};

  assign enable_pattern = check_for_errors;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (words_checked == count_q) state_nx = DONE;
      end
      DONE: begin
        if (start) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pair;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q          <= '0;
      words_accepted   <= '0;
      words_checked    <= '0;
      overflow_err     <= 1'b0;
      half_vld         <= 1'b0;
      half_q           <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      data_to_check    <= '0;
      check_for_errors <= 1'b0;
    end else begin
      if (launch) begin
        count_q        <= word_count;
        words_accepted <= '0;
        words_checked  <= '0;
        overflow_err   <= 1'b0;
        half_vld       <= 1'b0;
      end else begin
        if (busy && pipe_write && !pipe_ready) begin
          overflow_err <= 1'b1;
        end
        if (accept) begin
          half_vld <= !half_vld;
        end
        if (accept && !half_vld) begin
          half_q <= pipe_data;
        end
        if (push) begin
          words_accepted <= words_accepted + 32'd1;
        end
        if (pop) begin
          words_checked <= words_checked + 32'd1;
        end
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        data_to_check <= mem[rd_ptr];
      end
      check_for_errors <= pop;

      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_word_packer.sv
// Directed bench for pipe_word_packer: both half orderings,
// backpressure, overflow, zero length, limit and mid-transfer reset.
module tb_pipe_word_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] word_count = '0;
  logic [31:0] pipe_data = '0;
  logic        pipe_write = 1'b0;
  logic        hold = 1'b0;

  logic        r0, c0, e0, b0, dn0, o0;
  logic [63:0] d0;
  logic [31:0] w0;
  logic        r1, c1, e1, b1, dn1, o1;
  logic [63:0] d1;
  logic [31:0] w1;

  int total = 0;
  int passed = 0;
  int pat_err = 0;
  int ncyc = 0;
  int src_idx = 0;
  int acc = 0;
  int n;
  int bad;
  bit feed_en = 1'b0;
  bit respect = 1'b1;

  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic [31:0] src [$];
  int          scyc [$];

  always #5 clk = ~clk;

  pipe_word_packer #(.DEPTH(8), .SWAP_HALVES(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start),
    .word_count(word_count), .pipe_data(pipe_data),
    .pipe_write(pipe_write), .pipe_ready(r0), .hold(hold),
    .data_to_check(d0), .check_for_errors(c0),
    .enable_pattern(e0), .busy(b0), .done(dn0),
    .overflow_err(o0), .words_checked(w0)
  );

  pipe_word_packer #(.DEPTH(8), .SWAP_HALVES(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .word_count(word_count), .pipe_data(pipe_data),
    .pipe_write(pipe_write), .pipe_ready(r1), .hold(hold),
    .data_to_check(d1), .check_for_errors(c1),
    .enable_pattern(e1), .busy(b1), .done(dn1),
    .overflow_err(o1), .words_checked(w1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: observed %h expected %h",
               tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // one cycle: sample at negedge, then drive the feeder
  task automatic step();
    @(negedge clk);
    ncyc++;
    if (c0) begin
      q0.push_back(d0);
      scyc.push_back(ncyc);
    end
    if (c1) q1.push_back(d1);
    if (c0 !== e0 || c1 !== e1) pat_err++;
    if (feed_en) begin
      if (src_idx < src.size() && (r0 || !respect)) begin
        pipe_write = 1'b1;
        pipe_data  = src[src_idx];
        src_idx++;
        if (r0) acc++;
      end else begin
        pipe_write = 1'b0;
      end
    end
  endtask

  task automatic setup_feed(input int cnt,
                            input logic [31:0] base,
                            input bit resp);
    src.delete();
    for (int i = 0; i < cnt; i++) src.push_back(base + i);
    src_idx = 0;
    acc     = 0;
    respect = resp;
    feed_en = 1'b1;
    q0.delete();
    q1.delete();
    scyc.delete();
  endtask

  task automatic stop_feed();
    feed_en    = 1'b0;
    pipe_write = 1'b0;
  endtask

  task automatic begin_xfer(input logic [31:0] cnt);
    start      = 1'b1;
    word_count = cnt;
    step();
    start = 1'b0;
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_data", d0, 64'h0);
    chk("rst_strobe", {c0, e0}, 2'b00);
    chk("rst_status", {b0, dn0, o0, r0}, 4'b0000);
    chk("rst_wc", w0, 32'd0);
    reset = 1'b0;
    step();
    chk("idle_ready", r0, 1'b0);

    // basic transfer, both half orderings
    setup_feed(4, 32'h0, 1'b1);
    src = '{32'h11111111, 32'h22222222,
            32'h33333333, 32'h44444444};
    begin_xfer(32'd2);
    n = 0;
    while (q0.size() < 2 && n < 30) begin
      step();
      n++;
    end
    chk("basic_cnt", q0.size(), 2);
    chk("basic_wc", w0, 32'd2);
    chk("basic_w0", q0[0], 64'h22222222_11111111);
    chk("basic_w1", q0[1], 64'h44444444_33333333);
    chk("swap_w0", q1[0], 64'h11111111_22222222);
    chk("swap_w1", q1[1], 64'h33333333_44444444);
    chk("basic_lat", scyc[1] - scyc[0], 2);
    step();
    chk("basic_done", {dn0, b0}, 2'b10);
    step();
    step();
    chk("basic_no_extra", q0.size(), 2);
    chk("basic_wc_hold", w0, 32'd2);
    stop_feed();

    // backpressure with hold
    hold = 1'b1;
    setup_feed(24, 32'hA0000000, 1'b1);
    begin_xfer(32'd12);
    for (int i = 0; i < 40; i++) step();
    chk("bp_accepted", acc, 16);
    chk("bp_ready", r0, 1'b0);
    chk("bp_no_strobe", q0.size(), 0);
    hold = 1'b0;
    n = 0;
    while (q0.size() < 12 && n < 80) begin
      step();
      n++;
    end
    chk("bp_cnt", q0.size(), 12);
    chk("bp_back2back", scyc[11] - scyc[0], 11);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (q0[k] !== {32'hA0000000 + 2*k + 1,
                     32'hA0000000 + 2*k}) bad++;
    end
    chk("bp_order", bad, 0);
    step();
    chk("bp_done", dn0, 1'b1);
    chk("bp_no_ovf", o0, 1'b0);
    chk("bp_all_in", acc, 24);
    stop_feed();

    // overflow with FIFO full
    hold = 1'b1;
    setup_feed(16, 32'hB0000000, 1'b1);
    begin_xfer(32'd8);
    for (int i = 0; i < 24; i++) step();
    chk("ovf_full", r0, 1'b0);
    stop_feed();
    pipe_write = 1'b1;
    pipe_data  = 32'hDEADBEEF;
    step();
    pipe_write = 1'b0;
    step();
    chk("ovf_set", o0, 1'b1);
    step();
    step();
    hold = 1'b0;
    n = 0;
    while (!dn0 && n < 40) begin
      step();
      n++;
    end
    chk("ovf_cnt", q0.size(), 8);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (q0[k] !== {32'hB0000000 + 2*k + 1,
                     32'hB0000000 + 2*k}) bad++;
    end
    chk("ovf_data", bad, 0);
    chk("ovf_sticky", o0, 1'b1);

    // zero length, also clears overflow
    q0.delete();
    begin_xfer(32'd0);
    chk("zero_ovf_clr", o0, 1'b0);
    chk("zero_run", {b0, r0}, 2'b10);
    step();
    chk("zero_done", dn0, 1'b1);
    chk("zero_no_strobe", q0.size(), 0);

    // count limit with an extra pipe word
    setup_feed(3, 32'hC0000000, 1'b0);
    begin_xfer(32'd1);
    n = 0;
    while (!dn0 && n < 20) begin
      step();
      n++;
    end
    stop_feed();
    chk("lim_acc", acc, 2);
    chk("lim_ovf", o0, 1'b1);
    chk("lim_cnt", q0.size(), 1);
    chk("lim_w0", q0[0], 64'hC0000001_C0000000);
    chk("lim_swap", q1[0], 64'hC0000000_C0000001);

    // reset mid-transfer
    setup_feed(8, 32'hD0000000, 1'b1);
    begin_xfer(32'd4);
    n = 0;
    while (acc < 3 && n < 20) begin
      step();
      n++;
    end
    step();
    stop_feed();
    reset = 1'b1;
    step();
    chk("mid_data", d0, 64'h0);
    chk("mid_data_sw", d1, 64'h0);
    chk("mid_strobe", {c0, e0}, 2'b00);
    chk("mid_status", {b0, dn0, o0, r0}, 4'b0000);
    chk("mid_wc", w0, 32'd0);
    reset = 1'b0;
    setup_feed(2, 32'hE0000000, 1'b1);
    begin_xfer(32'd1);
    n = 0;
    while (!dn0 && n < 20) begin
      step();
      n++;
    end
    stop_feed();
    chk("fresh_cnt", q0.size(), 1);
    chk("fresh_w0", q0[0], 64'hE0000001_E0000000);
    chk("fresh_wc", w0, 32'd1);

    chk("strobe_eq_enable", pat_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
